imem_loader: RTL

Writer side of the instruction memory: receives a program as a byte stream and writes it into the instruction memory's word array as 32-bit little-endian words. Sits between a byte source (UART receiver or test harness) and the instruction memory write port. Holds the CPU in reset until a load completes cleanly. Replaces preloading from a file at elaboration with a run-time load path.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_if.sv | 13 +
 rtl/imem_word_assembler.sv | 37 +++
 rtl/imem_loader.sv | 123 ++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (input rx_data, rx_valid, output rx_ready, we, waddr, wdata);
  modport slave  (output rx_data, rx_valid, input rx_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_vld pulses the cycle after
// the 4th byte. No backpressure of its own: the caller gates byte_vld.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        byte_last,
  output logic        word_vld,
  output logic [31:0] word_dat
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt;

  assign byte_last = byte_vld && (cnt == CNT_W'(BYTES_PER_WORD - 1));

  // Bytes enter at the top so the first byte ends up in the low lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= byte_last && !clr;
      if (clr) begin
        cnt <= '0;
      end else if (byte_vld) begin
        cnt      <= cnt + 1'b1;
        word_dat <= {byte_dat, word_dat[31:8]};
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory; one write per 4 bytes,
// issued the cycle after the 4th byte. Optional trailing XOR byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 62,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_rst_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);
  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   n_q, word_idx_q, n_rx;
  logic [7:0]           len_lo_q;
  logic [31:0]          waddr_q;
  logic                 last_q, last_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 xfer, load_start;
  logic                 asm_last, asm_vld;
  logic [31:0]          asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           xor_q;
`endif

  assign xfer       = bus.rx_valid && rx_ready_q;
  assign load_start = start && (state_q inside {IDLE, DONE, ERR});
  assign n_rx       = {bus.rx_data, len_lo_q};

  imem_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (load_start),
    .byte_vld (xfer && (state_q == DATA)),
    .byte_dat (bus.rx_data),
    .byte_last(asm_last),
    .word_vld (asm_vld),
    .word_dat (asm_word)
  );

  assign bus.we       = asm_vld;
  assign bus.wdata    = asm_word;
  assign bus.waddr    = waddr_q;
  assign bus.rx_ready = rx_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN_LO;
      LEN_LO: if (xfer) state_d = LEN_HI;
      LEN_HI: if (xfer) state_d = ((n_rx == '0) || (n_rx > COUNT_W'(DEPTH))) ? ERR : DATA;
      DATA: begin
        if (asm_last && (word_idx_q == n_q - 1'b1)) last_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (asm_vld && last_q) state_d = CHK;
`else
        if (asm_vld && last_q) state_d = DONE;
`endif
      end
      CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer) state_d = (bus.rx_data == xor_q) ? DONE : ERR;
`else
        state_d = ERR;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (load_start) last_d = 1'b0;
  end

  // Ready drops as soon as the final payload byte is taken, so nothing trails in.
  always_comb begin
    busy         = state_q inside {LEN_LO, LEN_HI, DATA, CHK};
    done         = (state_q == DONE);
    error        = (state_q == ERR);
    cpu_rst_hold = (state_q != DONE);
    rx_ready_d   = (state_d inside {LEN_LO, LEN_HI, DATA, CHK}) &&
                   !((state_d == DATA) && last_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
      last_q     <= 1'b0;
      len_lo_q   <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      waddr_q    <= BASE_ADDR;
    end else begin
      rx_ready_q <= rx_ready_d;
      last_q     <= last_d;
      if (load_start) begin
        word_idx_q <= '0;
        waddr_q    <= BASE_ADDR;
      end else if (asm_vld && !last_q) begin
        word_idx_q <= word_idx_q + 1'b1;
        waddr_q    <= waddr_q + 32'd4;
      end
      if ((state_q == LEN_LO) && xfer) len_lo_q <= bus.rx_data;
      if ((state_q == LEN_HI) && xfer) n_q <= n_rx;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            xor_q <= '0;
    else if (load_start)                xor_q <= '0;
    else if ((state_q == DATA) && xfer) xor_q <= xor_q ^ bus.rx_data;
  end
`endif
endmodule
